// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO push-side packet arbiter.
// The beat layout is {eop, payload}, so the EOP flag is the bit at index DATA_WIDTH.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Widest beat the EOP helper accepts; callers zero-extend into it.
  localparam int MAX_BEAT_W = 1024;

  function automatic logic eop_of(input logic [MAX_BEAT_W-1:0] beat, input int eop_bit);
    return beat[eop_bit[9:0]];
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: returns the first set request at or after rr_ptr,
// wrapping at NUM_REQ-1 by comparison so non-power-of-two counts work.
module rr_priority_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Walk the requests once, starting at rr_ptr, latching the first hit.
  always_comb begin
    idx     = rr_ptr;
    found_s = 1'b0;
    cand_s  = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_s && req[cand_s]) begin
        idx     = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
      if (cand_s == LAST_IDX) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + IDX_W'(1);
      end
    end
    any_valid = found_s;
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// Optional idle-owner watchdog is enabled with the FIFO_ARB_WATCHDOG_EN macro.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                req_grant_o,
  output logic                              push_valid_o,
  output logic [DATA_WIDTH:0]               push_data_o,
  input  logic                              push_grant_i,
  output logic [$clog2(NUM_REQ)-1:0]        owner_o,
  output logic                              locked_o,
  output logic                              timeout_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int BEAT_W  = DATA_WIDTH + 1;
  localparam int EOP_BIT = DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0] owner_r, owner_nxt_s;
  logic [IDX_W-1:0] pick_idx_s, sel_s;
  logic             pick_any_s, sel_valid_s, xfer_s, eop_s;
  logic [BEAT_W-1:0] sel_data_s;

`ifdef FIFO_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic             timeout_r, timeout_nxt_s;
`endif

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_r),
    .idx       (pick_idx_s),
    .any_valid (pick_any_s)
  );

  // A held lock pins the port to the owner; with nobody requesting the owner stays selected.
  always_comb begin
    if (state_r == ARB_LOCKED) begin
      sel_s = owner_r;
    end else if (pick_any_s) begin
      sel_s = pick_idx_s;
    end else begin
      sel_s = owner_r;
    end
  end

  assign sel_valid_s = req_valid_i[sel_s];
  assign sel_data_s  = req_data_i[int'(sel_s)*BEAT_W +: BEAT_W];
  assign xfer_s      = sel_valid_s & push_grant_i;
  assign eop_s       = eop_of(MAX_BEAT_W'(sel_data_s), EOP_BIT);

  // Only the selected producer may see a grant; everything is forced low in reset.
  always_comb begin
    req_grant_o = '0;
    if (rst_n) begin
      req_grant_o[sel_s] = push_grant_i & sel_valid_s;
    end else begin
      req_grant_o = '0;
    end
  end

  assign push_valid_o = rst_n & sel_valid_s;
  assign push_data_o  = rst_n ? sel_data_s : '0;
  assign owner_o      = rst_n ? sel_s : '0;
  assign locked_o     = rst_n & (state_r == ARB_LOCKED);
`ifdef FIFO_ARB_WATCHDOG_EN
  assign timeout_o    = rst_n & timeout_r;
`else
  assign timeout_o    = 1'b0;
`endif

  // Packet-level arbitration: lock on a non-EOP transfer, advance rr_ptr past the finisher.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    owner_nxt_s  = owner_r;
`ifdef FIFO_ARB_WATCHDOG_EN
    idle_cnt_nxt_s = '0;
    timeout_nxt_s  = 1'b0;
`endif
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s) begin
          owner_nxt_s = sel_s;
          if (eop_s) begin
            rr_ptr_nxt_s = wrap_inc(sel_s);
          end else begin
            state_nxt_s = ARB_LOCKED;
          end
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s && eop_s) begin
          state_nxt_s  = ARB_IDLE;
          rr_ptr_nxt_s = wrap_inc(owner_r);
`ifdef FIFO_ARB_WATCHDOG_EN
        end else if (!sel_valid_s) begin
          // Release once this idle cycle brings the run to TIMEOUT-1.
          if (idle_cnt_r == CNT_W'(TIMEOUT - 2)) begin
            state_nxt_s   = ARB_IDLE;
            rr_ptr_nxt_s  = wrap_inc(owner_r);
            timeout_nxt_s = 1'b1;
          end else begin
            idle_cnt_nxt_s = idle_cnt_r + CNT_W'(1);
          end
`endif
        end else begin
          state_nxt_s = ARB_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ARB_IDLE;
      rr_ptr_r <= '0;
      owner_r  <= '0;
`ifdef FIFO_ARB_WATCHDOG_EN
      idle_cnt_r <= '0;
      timeout_r  <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      owner_r  <= owner_nxt_s;
`ifdef FIFO_ARB_WATCHDOG_EN
      idle_cnt_r <= idle_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Self-checking bench for fifo_push_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level round-robin model.
module tb_fifo_push_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int TO = 4;
  localparam int BW = DW + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid, req_grant;
  logic [NR*BW-1:0] req_data;
  logic             push_valid, push_grant, locked, timeout;
  logic [BW-1:0]    push_data;
  logic [1:0]       owner;

  logic [2:0]       v3, g3;
  logic [3*BW-1:0]  d3;
  logic             pv3, pg3, l3, t3;
  logic [BW-1:0]    pd3;
  logic [1:0]       o3;

  int checks = 0;
  int errors = 0;

  int m_ptr, m_owner, m_idle;
  bit m_locked, m_tmo;

  fifo_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_grant_o(req_grant), .push_valid_o(push_valid), .push_data_o(push_data),
    .push_grant_i(push_grant), .owner_o(owner), .locked_o(locked), .timeout_o(timeout));

  fifo_push_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(3), .TIMEOUT(TO)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v3), .req_data_i(d3),
    .req_grant_o(g3), .push_valid_o(pv3), .push_data_o(pd3),
    .push_grant_i(pg3), .owner_o(o3), .locked_o(l3), .timeout_o(t3));

  function automatic logic [BW-1:0] beat(input logic e, input int val);
    return {e, 8'(val)};
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic drive(input logic [NR-1:0] v, input logic [NR*BW-1:0] d, input logic pg);
    req_valid  = v;
    req_data   = d;
    push_grant = pg;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    v3 = '0; d3 = '0; pg3 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [NR*BW-1:0] d;
    d = '1;
    rst_n = 1'b0;
    drive(4'b1111, d, 1'b1);
    #3;
    checks++;
    if ({req_grant, push_valid, push_data, owner, locked, timeout} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {req_grant, push_valid, push_data, owner, locked, timeout});
    end
    apply_reset();
  endtask

  task automatic test_rr_single_beat();
    logic [NR*BW-1:0] d;
    logic [3:0] eg;
    apply_reset();
    for (int r = 0; r < NR; r++) d[r*BW +: BW] = beat(1'b1, 16 + r);
    drive(4'b1111, d, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      eg = 4'(1 << (k % 4));
      checks++;
      if ({req_grant, locked, push_data} !== {eg, 1'b0, beat(1'b1, 16 + k % 4)}) begin
        errors++;
        $display("FAIL rr_order[%0d] got g=%b l=%b d=%h want g=%b l=0", k, req_grant, locked, push_data, eg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_packet_lock();
    logic [NR*BW-1:0] d;
    logic [3:0] eg;
    logic [BW-1:0] eb;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d = '0;
      d[1*BW +: BW] = beat(k == 2, 32 + k);
      d[2*BW +: BW] = beat(1'b1, 64);
      drive(k < 3 ? 4'b0110 : 4'b0100, d, 1'b1);
      @(negedge clk);
      eg = (k < 3) ? 4'b0010 : 4'b0100;
      eb = (k < 3) ? beat(k == 2, 32 + k) : beat(1'b1, 64);
      checks++;
      if ({req_grant, locked, push_data} !== {eg, (k == 1 || k == 2), eb}) begin
        errors++;
        $display("FAIL packet_lock[%0d] got g=%b l=%b d=%h want g=%b d=%h", k, req_grant, locked, push_data, eg, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fifo_full();
    logic [NR*BW-1:0] d;
    logic [BW-1:0] pkt[3];
    int bi[6] = '{0, 1, 1, 1, 2, 0};
    logic [5:0] pg_seq = 6'b111001;
    logic [3:0] eg_seq[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b1000};
    logic [BW-1:0] eb;
    pkt[0] = beat(1'b0, 8'hA0); pkt[1] = beat(1'b0, 8'hB0); pkt[2] = beat(1'b1, 8'hC0);
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      d = '0;
      d[0 +: BW] = pkt[bi[k]];
      d[3*BW +: BW] = beat(1'b1, 8'h77);
      drive(k < 5 ? 4'b1001 : 4'b1000, d, pg_seq[k]);
      @(negedge clk);
      eb = (k < 5) ? pkt[bi[k]] : beat(1'b1, 8'h77);
      checks++;
      if ({req_grant, owner, locked, push_valid, push_data} !==
          {eg_seq[k], (k < 5) ? 2'd0 : 2'd3, (k >= 1 && k <= 4), 1'b1, eb}) begin
        errors++;
        $display("FAIL fifo_full[%0d] got g=%b o=%0d l=%b d=%h want g=%b d=%h", k, req_grant, owner, locked, push_data, eg_seq[k], eb);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap3();
    logic [2:0] vs[3] = '{3'b100, 3'b011, 3'b011};
    logic [2:0] eg[3] = '{3'b100, 3'b001, 3'b010};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      d3 = {beat(1'b1, 8'h22), beat(1'b1, 8'h11), beat(1'b1, 8'h00)};
      v3 = vs[k];
      pg3 = 1'b1;
      @(negedge clk);
      checks++;
      if ({g3, l3, pv3} !== {eg[k], 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL wrap3[%0d] got g=%b l=%b want g=%b l=0", k, g3, l3, eg[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    logic [NR*BW-1:0] d;
    apply_reset();
    d = '0;
    d[2*BW +: BW] = beat(1'b0, 8'h5A);
    drive(4'b0100, d, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({locked, owner} !== {1'b1, 2'd2}) begin
      errors++;
      $display("FAIL areset_locked got l=%b o=%0d want l=1 o=2", locked, owner);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_grant, push_valid, push_data, owner, locked, timeout} !== 17'd0) begin
      errors++;
      $display("FAIL areset_outputs got %h want 0", {req_grant, push_valid, push_data, owner, locked, timeout});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    d[0 +: BW] = beat(1'b1, 8'h01);
    d[2*BW +: BW] = beat(1'b1, 8'h02);
    drive(4'b0101, d, 1'b1);
    @(negedge clk);
    checks++;
    if ({req_grant, owner, locked} !== {4'b0001, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL areset_after got g=%b o=%0d l=%b want g=0001 o=0 l=0", req_grant, owner, locked);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog();
    logic [NR*BW-1:0] d;
    logic [3:0] eg;
    logic el, et;
    apply_reset();
    d = '0;
    d[1*BW +: BW] = beat(1'b0, 8'h31);
    d[3*BW +: BW] = beat(1'b1, 8'h33);
    drive(4'b0010, d, 1'b1);
    @(negedge clk);
    checks++;
    if (req_grant !== 4'b0010) begin
      errors++;
      $display("FAIL wd_start got g=%b want 0010", req_grant);
    end
    @(posedge clk); #1;
    drive(4'b1000, d, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
`ifdef FIFO_ARB_WATCHDOG_EN
      el = (k < 4);
      et = (k == 4);
      eg = (k < 4) ? 4'b0000 : 4'b1000;
`else
      el = 1'b1;
      et = 1'b0;
      eg = 4'b0000;
`endif
      checks++;
      if ({locked, timeout, req_grant} !== {el, et, eg}) begin
        errors++;
        $display("FAIL watchdog[%0d] got l=%b t=%b g=%b want l=%b t=%b g=%b", k, locked, timeout, req_grant, el, et, eg);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] rv;
    logic [NR*BW-1:0] rd;
    logic [BW-1:0] eb;
    logic [3:0] eg;
    logic xfer, tmo_n;
    int p, sel;
    apply_reset();
    m_ptr = 0; m_owner = 0; m_idle = 0; m_locked = 1'b0; m_tmo = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        rv[r] = ($urandom_range(0, 99) < 70);
        rd[r*BW +: BW] = beat($urandom_range(0, 99) < 40, int'($urandom_range(0, 255)));
      end
      drive(rv, rd, $urandom_range(0, 99) < 75);
      @(negedge clk);
      p   = pick(rv, m_ptr);
      sel = m_locked ? m_owner : ((p >= 0) ? p : m_owner);
      eb  = rd[sel*BW +: BW];
      eg  = (push_grant && rv[sel]) ? 4'(1 << sel) : 4'b0000;
      checks++;
      if ({req_grant, push_valid, push_data, owner, locked, timeout} !==
          {eg, rv[sel], eb, 2'(sel), m_locked, m_tmo}) begin
        errors++;
        $display("FAIL random[%0d] got g=%b v=%b d=%h o=%0d l=%b t=%b want g=%b v=%b d=%h o=%0d l=%b t=%b",
                 c, req_grant, push_valid, push_data, owner, locked, timeout,
                 eg, rv[sel], eb, sel, m_locked, m_tmo);
      end
      xfer  = rv[sel] && push_grant;
      tmo_n = 1'b0;
      if (!m_locked) begin
        if (xfer) begin
          m_owner = sel;
          if (eb[DW]) m_ptr = (sel + 1) % NR;
          else begin m_locked = 1'b1; m_idle = 0; end
        end
      end else if (xfer && eb[DW]) begin
        m_locked = 1'b0;
        m_ptr = (m_owner + 1) % NR;
      end
`ifdef FIFO_ARB_WATCHDOG_EN
      else if (!rv[m_owner]) begin
        m_idle++;
        if (m_idle == TO - 1) begin
          m_locked = 1'b0;
          m_ptr = (m_owner + 1) % NR;
          m_idle = 0;
          tmo_n = 1'b1;
        end
      end else begin
        m_idle = 0;
      end
`endif
      m_tmo = tmo_n;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rr_single_beat();
    test_packet_lock();
    test_fifo_full();
    test_wrap3();
    test_async_reset();
    test_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
